// File: rtl/arm_hazard_scoreboard_pkg.sv
// rtl/arm_hazard_scoreboard_pkg.sv - shared types, select encoding and clog2 for the hazard scoreboard
package arm_hazard_scoreboard_pkg;

  // Entry dest is sized for the widest supported register file (NREG <= 256).
  localparam int MAX_RW = 8;
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic              valid;
    logic [MAX_RW-1:0] dest;
    logic              is_load;
  } entry_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/arm_hazard_cmp.sv
// rtl/arm_hazard_cmp.sv - operand-vs-stage destination comparator, one per tracked stage
module arm_hazard_cmp
  import arm_hazard_scoreboard_pkg::*;
#(
  parameter int RW = 4
) (
  input  entry_t          entry_i,
  input  logic [RW-1:0]   src1_i,
  input  logic [RW-1:0]   src2_i,
  input  logic            has_rn_i,
  input  logic            two_src_i,
  output logic            match1_o,
  output logic            match2_o
);

  assign match1_o = has_rn_i  & entry_i.valid & (entry_i.dest == MAX_RW'(src1_i));
  assign match2_o = two_src_i & entry_i.valid & (entry_i.dest == MAX_RW'(src2_i));

endmodule

// File: rtl/arm_hazard_scoreboard.sv
// rtl/arm_hazard_scoreboard.sv - ID-stage RAW hazard detection with optional forwarding selects
module arm_hazard_scoreboard
  import arm_hazard_scoreboard_pkg::*;
#(
  parameter  int NREG   = 16,
  parameter  int DEPTH  = 2,
  parameter  int FWD_EN = 0,
  parameter  int CW     = 16,
  localparam int RW     = clog2(NREG),
  localparam int SW     = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RW-1:0]    id_src1,
  input  logic [RW-1:0]    id_src2,
  input  logic             id_has_rn,
  input  logic             id_two_src,
  input  logic [RW-1:0]    id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             branch_taken,
  input  logic             stat_clr,
  output logic             hazard_detected,
  output logic [SW-1:0]    fwd_sel1,
  output logic [SW-1:0]    fwd_sel2,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CW-1:0]    stall_count
);

  entry_t [DEPTH-1:0] entry_q, entry_d;
  logic   [CW-1:0]    stall_q, stall_d;
  logic   [DEPTH-1:0] m1, m2;
  logic   [SW-1:0]    sel1, sel2;
  logic               hazard;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    arm_hazard_cmp #(.RW(RW)) u_cmp (
      .entry_i   (entry_q[k]),
      .src1_i    (id_src1),
      .src2_i    (id_src2),
      .has_rn_i  (id_has_rn),
      .two_src_i (id_two_src),
      .match1_o  (m1[k]),
      .match2_o  (m2[k])
    );
    assign stage_valid[k] = entry_q[k].valid;
  end

  always_comb begin
    hazard = 1'b0;
    sel1   = SW'(FWD_RF);
    sel2   = SW'(FWD_RF);
    if (FWD_EN == 0) begin
      hazard = (|m1) | (|m2);
    end else begin
      // Only a load still in EXE cannot be forwarded in time.
      hazard = entry_q[0].is_load & (m1[0] | m2[0]);
      // Walk oldest to youngest so the youngest matching stage wins.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (m1[k]) sel1 = SW'(k + 1);
        if (m2[k]) sel2 = SW'(k + 1);
      end
      if (hazard) begin
        sel1 = SW'(FWD_RF);
        sel2 = SW'(FWD_RF);
      end
    end
  end

  always_comb begin
    entry_d    = entry_q << $bits(entry_t);
    entry_d[0] = '0;
    if (id_wb_en && !hazard && !branch_taken) begin
      entry_d[0].valid   = 1'b1;
      entry_d[0].dest    = MAX_RW'(id_dest);
      entry_d[0].is_load = id_mem_r_en;
    end
    stall_d = stall_q;
    if (stat_clr) begin
      stall_d = '0;
    end else if (hazard && !branch_taken && (stall_q != {CW{1'b1}})) begin
      stall_d = stall_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q <= '0;
      stall_q <= '0;
    end else begin
      entry_q <= entry_d;
      stall_q <= stall_d;
    end
  end

  assign hazard_detected = hazard;
  assign fwd_sel1        = sel1;
  assign fwd_sel2        = sel2;
  assign stall_count     = stall_q;

endmodule

// File: doc/arm_hazard_scoreboard.md
ARM_HAZARD_SCOREBOARD -- requirements
Module: arm_hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 16, number of architectural registers.
REQ-002 Parameter DEPTH, default 2, number of tracked post-ID stages (stage 0 = EXE, stage DEPTH-1 = last stage before WB); legal range 1..6.
REQ-003 Parameter FWD_EN, default 0; 0 = stall-only mode, 1 = forwarding mode.
REQ-004 Parameter CW, default 16, stall-counter width.
REQ-005 Derived RW = clog2(NREG); SW = clog2(DEPTH+1).
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 id_src1  input  RW  Rn index of the instruction in ID.
REQ-009 id_src2  input  RW  Rm/Rd-store index of the instruction in ID.
REQ-010 id_has_rn  input  1  src1 is a real operand.
REQ-011 id_two_src  input  1  src2 is a real operand.
REQ-012 id_dest  input  RW  destination of the ID instruction.
REQ-013 id_wb_en  input  1  ID instruction writes a register.
REQ-014 id_mem_r_en  input  1  ID instruction is a load.
REQ-015 branch_taken  input  1  flush: ID instruction is squashed this cycle.
REQ-016 stat_clr  input  1  synchronous clear of stall_count.
REQ-017 hazard_detected  output  1  stall IF/ID this cycle (combinational).
REQ-018 fwd_sel1, fwd_sel2  output  SW each  0 = register file, k = forward from stage k-1 (combinational).
REQ-019 stage_valid  output  DEPTH  registered valid bit of each tracked stage.
REQ-020 stall_count  output  CW  saturating count of stall cycles.

Function
REQ-021 Block SHALL hold a DEPTH-entry shift pipeline; each entry = {valid, dest[RW], is_load}.
REQ-022 Each clock: entry[i] <= entry[i-1] for i >= 1; entry DEPTH-1 is discarded (WB visibility is provided by the falling-edge register-file write).
REQ-023 entry[0] SHALL load {1, id_dest, id_mem_r_en} when id_wb_en=1, hazard_detected=0 and branch_taken=0; otherwise it SHALL load a bubble (valid=0).
REQ-024 Operand match k for src1 SHALL be: id_has_rn & entry[k].valid & entry[k].dest == id_src1; src2 likewise, gated by id_two_src.
REQ-025 FWD_EN=0: hazard_detected = any match on either operand in any stage; fwd_sel1 = fwd_sel2 = 0.
REQ-026 FWD_EN=1: hazard_detected = match in stage 0 with entry[0].is_load=1 (load-use); otherwise no stall.
REQ-027 FWD_EN=1: fwd_selN = k+1 for the lowest k (youngest) matching stage, 0 if none; priority youngest-first when several stages hold the same dest.
REQ-028 Selects SHALL be 0 whenever hazard_detected=1.
REQ-029 branch_taken and hazard_detected together: bubble inserted (REQ-023), hazard still reported, pipeline still shifts.
REQ-030 Register index 15 (PC) SHALL be treated as an ordinary index; no special case.
REQ-031 stall_count SHALL increment by 1 in each cycle with hazard_detected=1 and branch_taken=0, saturating at 2^CW-1.
REQ-032 stat_clr=1 SHALL set stall_count to 0 on that edge, overriding an increment.

Reset
REQ-033 While rst=0 all entry valid bits, stage_valid and stall_count SHALL be 0, independent of clk.
REQ-034 With all entries invalid, hazard_detected=0 and fwd_sel1=fwd_sel2=0 for any ID inputs.
REQ-035 Reset asserted mid-stall SHALL drop the stall immediately (combinationally from cleared state).

Structure
REQ-036 Shared package SHALL hold the entry struct type, forward-select encoding constants (FWD_RF=0) and the clog2 function.
REQ-037 One sub-module arm_hazard_cmp (per-stage operand comparator, one instance per stage) is natural; comparison logic SHALL not be duplicated otherwise.

Verification
REQ-038 FWD_EN=0: issue ADD r3 (wb_en), next cycle ID reads r3 as src1 -> hazard_detected=1 for 2 cycles, then 0; stall_count=2.
REQ-039 FWD_EN=1: ADD r3 then SUB using r3 -> hazard_detected=0, fwd_sel1=1; one cycle later dependent -> fwd_sel1=2.
REQ-040 FWD_EN=1: LDR r5 then ADD using r5 as src2 with id_two_src=1 -> hazard 1 cycle, then fwd_sel2=2; same with id_two_src=0 -> no hazard.
REQ-041 Writes to r2 in stages 0 and 1, ID reads r2 -> fwd_sel1=1 (youngest wins).
REQ-042 branch_taken=1 with id_wb_en=1, id_dest=r7 -> next cycle stage_valid[0]=0; later read of r7 -> no hazard.
REQ-043 CW=4, force continuous load-use stall 20 cycles -> stall_count holds 15; stat_clr -> 0; rst low mid-stall -> hazard_detected=0 at once.
